mem_bank_ctrl: RTL and testbench

Parametrised single-port memory bank with a built-in initialisation sequencer, a valid/ready request port, 1-cycle read responses and a watched-location change monitor. It is the synthesizable, generalised successor to our ad-hoc behavioural RAM arrays. It fills itself with a known pattern after reset and raises a pulse whenever a nominated word changes value. It sits between the bench/host request agent and the storage array.

---
 rtl/mem_bank_ctrl.sv | 166 ++++++++++++++++
 tb/tb_mem_bank_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_ctrl.sv
// mem_bank_ctrl
//   Single-port memory bank. After reset (or on request) it fills every word
//   with a known pattern, then serves one valid/ready request per cycle with
//   a one-cycle read response. It also mirrors one nominated word and pulses
//   whenever that word takes a new value.
//
// Ports
//   clk, reset_n               clock (rising edge), async active-low reset
//   init_start                 one-cycle request to re-run the fill (READY only)
//   init_done                  bank filled and serving requests
//   req_valid/req_ready        request handshake
//   req_write, req_addr,
//   req_wdata                  request payload
//   resp_valid, resp_rdata,
//   resp_error                 response, one cycle after acceptance
//   watch_changed, watch_data  change pulse and mirror of word WATCH_ADDR
module mem_bank_ctrl #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 1718,
    parameter int ADDR_WIDTH = 11,
    parameter int INIT_MODE  = 1,
    parameter int WATCH_ADDR = 175
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  init_start,
    output logic                  init_done,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error,
    output logic                  watch_changed,
    output logic [DATA_WIDTH-1:0] watch_data
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] WATCH_A    = ADDR_WIDTH'(WATCH_ADDR);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_next;

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic                    req_acc_p0;
    logic                    req_oor_p0;

    logic                    vld_p1;
    logic                    err_p1;
    logic [DATA_WIDTH-1:0]   rdata_p1;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Fill value for a given word: zero, or the address zero-extended /
    // truncated to the word width.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
        if (INIT_MODE != 0) return DATA_WIDTH'(a);
        else                return '0;
    endfunction

    assign req_acc_p0 = req_valid && req_ready;
    assign req_oor_p0 = {1'b0, req_addr} >= DEPTH_EXT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The write port is shared: the fill sequencer owns it in INIT, the
    // request port in READY. Writes are held off while reset is asserted so
    // the array is left alone during reset.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        init_done  = 1'b0;
        req_ready  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = req_addr;
        wr_data    = req_wdata;
        case (state)
            ST_INIT: begin
                wr_en    = reset_n;
                wr_addr  = cnt;
                wr_data  = pattern(cnt);
                cnt_next = cnt + 1'b1;
                if (cnt == LAST_ADDR) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end
            end
            ST_READY: begin
                init_done = 1'b1;
                req_ready = 1'b1;
                wr_en     = req_valid && req_write && !req_oor_p0;
                if (init_start) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Response stage: registered at the accepting edge. Reading the array
    // here sees any write made on an earlier edge, so read-after-write on
    // the following cycle returns the new value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            if (req_acc_p0) begin
                if (req_oor_p0) begin
                    vld_p1   <= 1'b1;
                    err_p1   <= 1'b1;
                    rdata_p1 <= '0;
                end else if (!req_write) begin
                    vld_p1   <= 1'b1;
                    rdata_p1 <= mem[req_addr];
                end
            end
        end
    end

    assign resp_valid = vld_p1;
    assign resp_error = err_p1;
    assign resp_rdata = rdata_p1;

    // Watch stage: mirrors the watched word from the shared write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            watch_changed <= 1'b0;
            watch_data    <= '0;
        end else begin
            watch_changed <= 1'b0;
            if (wr_en && (wr_addr == WATCH_A) && (wr_data != watch_data)) begin
                watch_data    <= wr_data;
                watch_changed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bank_ctrl.sv
module tb_mem_bank_ctrl;

    localparam int DW    = 18;
    localparam int DEPTH = 1718;
    localparam int AW    = 11;
    localparam int WA    = 175;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          init_start;
    logic          init_done;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_error;
    logic          watch_changed;
    logic [DW-1:0] watch_data;

    int errors = 0;
    int checks = 0;

    // Reference model: the array contents and the watched mirror value.
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_watch;

    mem_bank_ctrl #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .INIT_MODE(1), .WATCH_ADDR(WA)
    ) dut (
        .clk(clk), .reset_n(reset_n), .init_start(init_start), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .watch_changed(watch_changed), .watch_data(watch_data)
    );

    always #5 clk = ~clk;

    // The fill pattern is the address itself (it always fits in 18 bits).
    task automatic model_fill();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = DW'(i);
    endtask

    // Counts edges until init_done, recording watch pulses along the way.
    task automatic wait_init(output int cyc, output int pulses, output int pcyc);
        cyc = 0; pulses = 0; pcyc = -1;
        while (cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (watch_changed === 1'b1) begin pulses++; pcyc = cyc; end
            if (init_done === 1'b1) break;
        end
    endtask

    // Presents one request for one cycle and returns what appears on the
    // response/watch outputs in the cycle after acceptance.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic rv, output logic [DW-1:0] rd,
                         output logic re, output logic wc);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rv = resp_valid; rd = resp_rdata; re = resp_error; wc = watch_changed;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({init_done, req_ready, resp_valid, resp_error, watch_changed} !== 5'b0 ||
            resp_rdata !== '0 || watch_data !== '0) begin
            errors++;
            $display("FAIL %s: done=%b rdy=%b rv=%b re=%b wc=%b rd=%h wd=%h, all required 0",
                     tag, init_done, req_ready, resp_valid, resp_error, watch_changed,
                     resp_rdata, watch_data);
        end
    endtask

    task automatic check_init(input string tag, input int cyc, input int pulses, input int pcyc);
        checks++;
        if (cyc !== DEPTH) begin
            errors++; $display("FAIL %s_latency: init_done after %0d cycles, required %0d", tag, cyc, DEPTH);
        end
        checks++;
        if (pulses !== 1 || pcyc !== WA + 1) begin
            errors++; $display("FAIL %s_watch_pulse: %0d pulses at cycle %0d, required 1 at %0d",
                               tag, pulses, pcyc, WA + 1);
        end
        checks++;
        if (watch_data !== model_watch) begin
            errors++; $display("FAIL %s_watch_data: got %h required %h", tag, watch_data, model_watch);
        end
    endtask

    task automatic test_reset();
        int cyc, pulses, pcyc;
        reset_n = 1'b1; init_start = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset_state");
        @(negedge clk);
        reset_n = 1'b1;
        model_fill(); model_watch = DW'(WA);
        wait_init(cyc, pulses, pcyc);
        check_init("init", cyc, pulses, pcyc);
    endtask

    task automatic test_read_last();
        logic rv, re, wc; logic [DW-1:0] rd;
        issue(1'b0, AW'(DEPTH - 1), '0, rv, rd, re, wc);
        checks++;
        if (rv !== 1'b1 || re !== 1'b0 || rd !== model_mem[DEPTH-1] || rd !== 18'h006B5) begin
            errors++; $display("FAIL read_last: rv=%b re=%b rd=%h, required 1 0 %h", rv, re, rd, 18'h006B5);
        end
    endtask

    task automatic test_watch();
        logic rv, re, wc; logic [DW-1:0] rd;
        issue(1'b1, AW'(WA), 18'h3, rv, rd, re, wc);
        checks++;
        if (wc !== 1'b1 || rv !== 1'b0 || watch_data !== 18'h3) begin
            errors++; $display("FAIL watch_first: wc=%b rv=%b wd=%h, required 1 0 00003", wc, rv, watch_data);
        end
        issue(1'b1, AW'(WA), 18'h3, rv, rd, re, wc);
        checks++;
        if (wc !== 1'b0 || watch_data !== 18'h3) begin
            errors++; $display("FAIL watch_equal: wc=%b wd=%h, required 0 00003", wc, watch_data);
        end
        model_mem[WA] = 18'h3; model_watch = 18'h3;
        issue(1'b0, AW'(WA), '0, rv, rd, re, wc);
        checks++;
        if (rv !== 1'b1 || re !== 1'b0 || rd !== model_mem[WA]) begin
            errors++; $display("FAIL watch_read: rv=%b re=%b rd=%h, required 1 0 %h", rv, re, rd, model_mem[WA]);
        end
    endtask

    task automatic test_back_to_back();
        logic wr_rv;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 11'd44; req_wdata = 18'h3FFFF;
        @(negedge clk);
        wr_rv = resp_valid;
        req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        model_mem[44] = 18'h3FFFF;
        checks++;
        if (wr_rv !== 1'b0) begin
            errors++; $display("FAIL b2b_write_resp: resp_valid=%b after write, required 0", wr_rv);
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== model_mem[44]) begin
            errors++; $display("FAIL b2b_read: rv=%b re=%b rd=%h, required 1 0 %h",
                               resp_valid, resp_error, resp_rdata, model_mem[44]);
        end
    endtask

    task automatic test_out_of_range();
        logic rv, re, wc; logic [DW-1:0] rd; logic [DW-1:0] wd_before;
        issue(1'b0, 11'd1718, '0, rv, rd, re, wc);
        checks++;
        if (rv !== 1'b1 || re !== 1'b1 || rd !== '0) begin
            errors++; $display("FAIL oor_read: rv=%b re=%b rd=%h, required 1 1 00000", rv, re, rd);
        end
        wd_before = watch_data;
        issue(1'b1, 11'd2047, 18'h1, rv, rd, re, wc);
        checks++;
        if (rv !== 1'b1 || re !== 1'b1 || rd !== '0 || wc !== 1'b0 || watch_data !== wd_before) begin
            errors++; $display("FAIL oor_write: rv=%b re=%b rd=%h wc=%b, required 1 1 00000 0", rv, re, rd, wc);
        end
        issue(1'b0, 11'd1717, '0, rv, rd, re, wc);
        checks++;
        if (rv !== 1'b1 || re !== 1'b0 || rd !== model_mem[1717]) begin
            errors++; $display("FAIL oor_after: rv=%b re=%b rd=%h, required 1 0 %h", rv, re, rd, model_mem[1717]);
        end
    endtask

    task automatic test_random();
        logic rv, re, wc; logic [DW-1:0] rd;
        logic w, oor, exp_rv, exp_wc; logic [AW-1:0] a; logic [DW-1:0] d, exp_rd;
        int bad = 0;
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = AW'(WA);
                1:       a = AW'($urandom_range(DEPTH, 2047));
                default: a = AW'($urandom_range(0, DEPTH - 1));
            endcase
            d = ($urandom_range(0, 3) == 0) ? model_watch : DW'($urandom);
            oor = (int'(a) >= DEPTH);
            exp_rv = oor || !w;
            exp_rd = oor ? '0 : (w ? '0 : model_mem[a]);
            exp_wc = 1'b0;
            if (w && !oor) begin
                model_mem[a] = d;
                if (int'(a) == WA && d != model_watch) begin exp_wc = 1'b1; model_watch = d; end
            end
            issue(w, a, d, rv, rd, re, wc);
            checks++;
            if (rv !== exp_rv || re !== oor || wc !== exp_wc ||
                (exp_rv && rd !== exp_rd) || watch_data !== model_watch) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_%0d: w=%b a=%0d rv=%b re=%b rd=%h wc=%b wd=%h, required %b %b %h %b %h",
                             n, w, a, rv, re, rd, wc, watch_data, exp_rv, oor, exp_rd, exp_wc, model_watch);
                bad++;
            end
        end
    endtask

    task automatic test_init_start();
        int cyc, pulses, pcyc;
        logic rv, re, wc; logic [DW-1:0] rd;
        // Make the watched word differ from its fill value first.
        issue(1'b1, AW'(WA), 18'h3, rv, rd, re, wc);
        model_mem[WA] = 18'h3; model_watch = 18'h3;
        @(negedge clk);
        init_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 11'd10;
        @(posedge clk);
        @(negedge clk);
        init_start = 1'b0; req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== model_mem[10]) begin
            errors++; $display("FAIL init_start_read: rv=%b re=%b rd=%h, required 1 0 %h",
                               resp_valid, resp_error, resp_rdata, model_mem[10]);
        end
        checks++;
        if (init_done !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL init_start_drop: done=%b rdy=%b, required 0 0", init_done, req_ready);
        end
        model_fill(); model_watch = DW'(WA);
        wait_init(cyc, pulses, pcyc);
        check_init("reinit", cyc, pulses, pcyc);
        issue(1'b0, AW'(WA), '0, rv, rd, re, wc);
        checks++;
        if (rv !== 1'b1 || rd !== model_mem[WA]) begin
            errors++; $display("FAIL reinit_read: rv=%b rd=%h, required 1 %h", rv, rd, model_mem[WA]);
        end
    endtask

    task automatic test_mid_reset();
        int cyc, pulses, pcyc;
        logic rv, re, wc; logic [DW-1:0] rd;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (500) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_watch = DW'(WA);
        wait_init(cyc, pulses, pcyc);
        check_init("mid_reset_init", cyc, pulses, pcyc);
        issue(1'b0, 11'd0, '0, rv, rd, re, wc);
        checks++;
        if (rv !== 1'b1 || re !== 1'b0 || rd !== model_mem[0]) begin
            errors++; $display("FAIL mid_reset_read0: rv=%b re=%b rd=%h, required 1 0 %h", rv, re, rd, model_mem[0]);
        end
    endtask

    initial begin
        test_reset();
        test_read_last();
        test_watch();
        test_back_to_back();
        test_out_of_range();
        test_random();
        test_init_start();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
